// File: rtl/cordic_pkg.sv
// Shared constants, FSM states and arctangent table for the iterative CORDIC rotator.
// All fixed-point values are signed Q2.30.
package cordic_pkg;

    localparam int CORDIC_W  = 32;
    localparam int FRAC_BITS = 30;

    // Gain compensation 1/An, preloaded into x so no post-scaling is needed.
    localparam logic signed [CORDIC_W-1:0] CORDIC_K  = 32'sh26DD3B6A;
    localparam logic signed [CORDIC_W-1:0] THETA_MAX = 32'sh40000000;
    localparam logic signed [CORDIC_W-1:0] THETA_MIN = 32'shC0000000;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } cordic_state_t;

    // atan(2^-i) * 2^30, rounded to nearest.
    function automatic logic signed [CORDIC_W-1:0] atan_lut(input logic [4:0] idx);
        logic signed [CORDIC_W-1:0] val;
        case (idx)
            5'd0:    val = 32'sh3243F6A9;
            5'd1:    val = 32'sh1DAC6705;
            5'd2:    val = 32'sh0FADBAFD;
            5'd3:    val = 32'sh07F56EA7;
            5'd4:    val = 32'sh03FEAB77;
            5'd5:    val = 32'sh01FFD55C;
            5'd6:    val = 32'sh00FFFAAB;
            5'd7:    val = 32'sh007FFF55;
            5'd8:    val = 32'sh003FFFEB;
            5'd9:    val = 32'sh001FFFFD;
            5'd10:   val = 32'sh00100000;
            5'd11:   val = 32'sh00080000;
            5'd12:   val = 32'sh00040000;
            5'd13:   val = 32'sh00020000;
            5'd14:   val = 32'sh00010000;
            5'd15:   val = 32'sh00008000;
            5'd16:   val = 32'sh00004000;
            5'd17:   val = 32'sh00002000;
            5'd18:   val = 32'sh00001000;
            5'd19:   val = 32'sh00000800;
            5'd20:   val = 32'sh00000400;
            5'd21:   val = 32'sh00000200;
            5'd22:   val = 32'sh00000100;
            5'd23:   val = 32'sh00000080;
            5'd24:   val = 32'sh00000040;
            5'd25:   val = 32'sh00000020;
            5'd26:   val = 32'sh00000010;
            5'd27:   val = 32'sh00000008;
            5'd28:   val = 32'sh00000004;
            5'd29:   val = 32'sh00000002;
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation in rotation mode; direction follows the sign of z.
module cordic_stage
    import cordic_pkg::*;
(
    input  logic signed [CORDIC_W-1:0] x,
    input  logic signed [CORDIC_W-1:0] y,
    input  logic signed [CORDIC_W-1:0] z,
    input  logic        [4:0]          shift,
    input  logic signed [CORDIC_W-1:0] angle,
    output logic signed [CORDIC_W-1:0] x_rot,
    output logic signed [CORDIC_W-1:0] y_rot,
    output logic signed [CORDIC_W-1:0] z_rot
);

    logic                       dir_pos;
    logic signed [CORDIC_W-1:0] x_shr;
    logic signed [CORDIC_W-1:0] y_shr;

    assign dir_pos = ~z[CORDIC_W-1];
    assign x_shr   = x >>> shift;
    assign y_shr   = y >>> shift;

    // Sums wrap at the datapath width; no saturation.
    assign x_rot = dir_pos ? (x - y_shr) : (x + y_shr);
    assign y_rot = dir_pos ? (y + x_shr) : (y - x_shr);
    assign z_rot = dir_pos ? (z - angle) : (z + angle);

endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator: one angle in, cos/sin out after ITER single-cycle micro-rotations,
// with valid/ready handshakes on both sides.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int ITER = 22,
    parameter int W    = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_theta,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_cos,
    output logic [W-1:0] out_sin,
    output logic         out_range_err
);

    localparam logic [4:0] LAST_I = 5'(ITER - 1);

    cordic_state_t     state_reg, state_next;
    logic signed [W-1:0] x_reg, x_next;
    logic signed [W-1:0] y_reg, y_next;
    logic signed [W-1:0] z_reg, z_next;
    logic [4:0]          i_reg, i_next;
    logic                range_reg, range_next;

    logic signed [W-1:0] x_rot;
    logic signed [W-1:0] y_rot;
    logic signed [W-1:0] z_rot;

    cordic_stage u_stage (
        .x     (x_reg),
        .y     (y_reg),
        .z     (z_reg),
        .shift (i_reg),
        .angle (atan_lut(i_reg)),
        .x_rot (x_rot),
        .y_rot (y_rot),
        .z_rot (z_rot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            i_reg     <= '0;
            range_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
            i_reg     <= i_next;
            range_reg <= range_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        z_next     = z_reg;
        i_next     = i_reg;
        range_next = range_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    x_next     = CORDIC_K;
                    y_next     = '0;
                    z_next     = in_theta;
                    i_next     = '0;
                    // Flag is judged on the accepted angle, never on the residual z.
                    range_next = ($signed(in_theta) > THETA_MAX) ||
                                 ($signed(in_theta) < THETA_MIN);
                    state_next = ROTATE;
                end
            end
            ROTATE: begin
                x_next = x_rot;
                y_next = y_rot;
                z_next = z_rot;
                if (i_reg == LAST_I) begin
                    state_next = DONE;
                end else begin
                    i_next = i_reg + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend on registered state only, so there is no input-to-output path.
    assign in_ready      = (state_reg == IDLE);
    assign out_valid     = (state_reg == DONE);
    assign out_cos       = x_reg;
    assign out_sin       = y_reg;
    assign out_range_err = range_reg;

endmodule

// File: tb/tb_cordic_rotator.sv
// Directed testbench for cordic_rotator: known angles, range flag, backpressure,
// throughput and asynchronous reset abort.
module tb_cordic_rotator;

    localparam int ITER = 22;
    localparam longint TOL = 768;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_theta;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_cos;
    logic [31:0] out_sin;
    logic        out_range_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_rotator #(.ITER(ITER), .W(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_theta      (in_theta),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_cos       (out_cos),
        .out_sin       (out_sin),
        .out_range_err (out_range_err)
    );

    // Angle, expected cos, expected sin (Q2.30) and expected range flag.
    logic [31:0] th_tab [5] = '{32'h00000000, 32'h40000000, 32'hC0000000, 32'h50000000, 32'hBFFFFFFF};
    logic [31:0] ec_tab [5] = '{32'h40000000, 32'd580145183, 32'd580145183, 32'd338574809, 32'd580145183};
    logic [31:0] es_tab [5] = '{32'h00000000, 32'd903522590, -32'sd903522590, 32'd1018964476, -32'sd903522590};
    logic        ee_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        longint d;
        d = longint'($signed(obs)) - longint'($signed(exp));
        if (d < 0) d = -d;
        vectors++;
        assert (d <= TOL) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, $signed(obs), $signed(exp), TOL);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [31:0] theta);
        bit ok;
        ok       = 1'b0;
        in_theta = theta;
        in_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk_eq("accept_timeout", {31'd0, ok}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk_eq("out_valid_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] held_cos;
        logic [31:0] held_sin;
        int          acc [2];
        int          nacc;
        bit          spurious;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_theta  = '0;
        #12;
        chk_eq("rst_in_ready",  {31'd0, in_ready},      32'd1);
        chk_eq("rst_out_valid", {31'd0, out_valid},     32'd0);
        chk_eq("rst_cos",       out_cos,                32'd0);
        chk_eq("rst_sin",       out_sin,                32'd0);
        chk_eq("rst_range",     {31'd0, out_range_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            send(th_tab[k]);
            wait_valid();
            chk_near($sformatf("cos[%08h]", th_tab[k]), out_cos, ec_tab[k]);
            chk_near($sformatf("sin[%08h]", th_tab[k]), out_sin, es_tab[k]);
            chk_eq($sformatf("range[%08h]", th_tab[k]), {31'd0, out_range_err}, {31'd0, ee_tab[k]});
            $display("angle 0x%08h -> cos 0x%08h sin 0x%08h range_err %0d", th_tab[k], out_cos, out_sin, out_range_err);
            release_out();
            chk_eq("ready_after_hs", {31'd0, in_ready},  32'd1);
            chk_eq("valid_after_hs", {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: results and handshake lines must stay frozen.
        send(32'h40000000);
        wait_valid();
        held_cos = out_cos;
        held_sin = out_sin;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk_eq("bp_valid", {31'd0, out_valid}, 32'd1);
            chk_eq("bp_ready", {31'd0, in_ready},  32'd0);
            chk_eq("bp_cos",   out_cos,            held_cos);
            chk_eq("bp_sin",   out_sin,            held_sin);
        end
        chk_near("bp_cos_value", held_cos, 32'd580145183);
        release_out();
        chk_eq("bp_ready_next", {31'd0, in_ready}, 32'd1);
        send(32'hC0000000);
        wait_valid();
        chk_near("b2b_cos", out_cos, 32'd580145183);
        chk_near("b2b_sin", out_sin, -32'sd903522590);
        $display("back-to-back angle 0xC0000000 -> cos 0x%08h sin 0x%08h", out_cos, out_sin);
        release_out();

        // Throughput with out_ready tied high and in_valid held.
        out_ready = 1'b1;
        in_theta  = 32'h20000000;
        in_valid  = 1'b1;
        nacc      = 0;
        for (int n = 0; n < 100 && nacc < 2; n++) begin
            if (in_ready) begin
                acc[nacc] = cyc;
                nacc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk_eq("tput_accepts", nacc, 32'd2);
        chk_eq("tput_period", acc[1] - acc[0], ITER + 2);
        $display("throughput: accepts at cycles %0d and %0d", acc[0], acc[1]);
        for (int n = 0; n < 60 && !in_ready; n++) @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of the rotation.
        @(negedge clk);
        send(32'h40000000);
        repeat (7) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_eq("abort_cos",   out_cos,                32'd0);
        chk_eq("abort_sin",   out_sin,                32'd0);
        chk_eq("abort_valid", {31'd0, out_valid},     32'd0);
        chk_eq("abort_range", {31'd0, out_range_err}, 32'd0);
        chk_eq("abort_ready", {31'd0, in_ready},      32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        spurious = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) spurious = 1'b1;
        end
        chk_eq("abort_no_valid",   {31'd0, spurious}, 32'd0);
        chk_eq("abort_ready_post", {31'd0, in_ready}, 32'd1);
        $display("reset abort: out_valid seen after release = %0d", spurious);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
